// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester APB master with round-robin arbitration.
// Each granted request runs one SETUP + ACCESS sequence on the APB bus and
// ends with a one-cycle done pulse (plus err on timeout) back to its requester.
module apb_rr_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic        write0,
    input  logic        write1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       last_grant;   // also identifies the owner of the transfer in flight

    logic elig0;
    logic elig1;
    logic winner;
    logic grant;
    logic fin_ok;
    logic fin_to;

    // Eligibility, round-robin winner and transfer-completion conditions
    always_comb begin
        elig0  = req0 & ~done0;
        elig1  = req1 & ~done1;
        winner = (elig0 & elig1) ? ~last_grant : elig1;
        grant  = (state == ST_IDLE) & (elig0 | elig1);
        fin_ok = (state == ST_ACCESS) & PREADY;
        fin_to = (state == ST_ACCESS) & ~PREADY & (wait_cnt == TO_LAST);
    end

    // Bus phase sequencing; PSEL/PENABLE are registered alongside the state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state <= ST_SETUP;
                        PSEL  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (fin_ok | fin_to) begin
                        state   <= ST_IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

    // ACCESS wait counter: cleared entering ACCESS, counts PREADY-low cycles
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !PREADY && !fin_to) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Latch the winner's request fields at grant; held until the next grant
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_grant <= 1'b1;
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
        end else if (grant) begin
            last_grant <= winner;
            PADDR      <= winner ? addr1  : addr0;
            PWDATA     <= winner ? wdata1 : wdata0;
            PWRITE     <= winner ? write1 : write0;
        end
    end

    // Completion response: one-cycle done/err to the owner, read data capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            rdata <= '0;
        end else begin
            done0 <= (fin_ok | fin_to) & ~last_grant;
            done1 <= (fin_ok | fin_to) &  last_grant;
            err0  <= fin_to & ~last_grant;
            err1  <= fin_to &  last_grant;
            if (fin_ok) begin
                rdata <= PRDATA;
            end else if (fin_to) begin
                rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed vector table, contention and reset sequences,
// then randomized traffic checked against a transaction-timeline model.
module tb_apb_rr_master;

    localparam int unsigned TO = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic        write0 = 1'b0, write1 = 1'b0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata, PADDR, PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    apb_rr_master #(.TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .write0(write0), .write1(write1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {25'd0, PSEL, PENABLE, PWRITE, done0, done1, err0, err1}, 32'd0);
        chk({name, "_paddr"}, PADDR, 32'd0);
        chk({name, "_pwdata"}, PWDATA, 32'd0);
        chk({name, "_rdata"}, rdata, 32'd0);
    endtask

    // Directed single-transfer vectors
    typedef struct {
        bit          who;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        int unsigned waits;      // PREADY-low ACCESS cycles before PREADY rises
        logic [31:0] prdata;
        int unsigned exp_cyc;    // cycles from request to done
        int unsigned exp_pen;    // PENABLE-high cycles
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic set_req(input bit who, input logic v, input logic [31:0] a,
                           input logic w, input logic [31:0] d);
        if (!who) begin req0 = v; addr0 = a; write0 = w; wdata0 = d; end
        else      begin req1 = v; addr1 = a; write1 = w; wdata1 = d; end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int unsigned cyc = 0, pen = 0, psel = 0;
        bit seen = 0, stable = 1, other = 0, got_err = 0;
        logic [31:0] got_rd = '0, s_addr = '0, s_wd = '0;
        logic s_wr = 1'b0;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge HCLK);
        set_req(v.who, 1'b1, v.addr, v.wr, v.wdata);
        PREADY = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge HCLK);
            cyc++;
            if (PSEL) psel++;
            if (PENABLE) pen++;
            if (PSEL && !PENABLE) begin s_addr = PADDR; s_wr = PWRITE; s_wd = PWDATA; end
            if (PSEL && (PWDATA !== v.wdata || PADDR !== v.addr)) stable = 0;
            if ((v.who ? done0 : done1) === 1'b1) other = 1;
            if ((v.who ? done1 : done0) === 1'b1) begin
                seen = 1;
                got_err = v.who ? err1 : err0;
                got_rd = rdata;
                set_req(v.who, 1'b0, v.addr, v.wr, v.wdata);
            end
            PREADY = PENABLE && (pen == v.waits + 1);
            PRDATA = PREADY ? v.prdata : $urandom();
        end
        PREADY = 1'b0;
        chk({tag, "_cycles"}, seen ? cyc : 999, v.exp_cyc);
        chk({tag, "_penable_cnt"}, pen, v.exp_pen);
        chk({tag, "_psel_cnt"}, psel, v.exp_pen + 1);
        chk({tag, "_err"}, {31'd0, got_err}, {31'd0, v.exp_err});
        chk({tag, "_rdata"}, got_rd, v.exp_rdata);
        chk({tag, "_paddr"}, s_addr, v.addr);
        chk({tag, "_pwrite"}, {31'd0, s_wr}, {31'd0, v.wr});
        chk({tag, "_pwdata"}, s_wd, v.wdata);
        chk({tag, "_stable"}, {31'd0, stable}, 32'd1);
        chk({tag, "_other_done"}, {31'd0, other}, 32'd0);
        @(negedge HCLK);
    endtask

    // Both requesters contend; each reasserts one cycle after its done
    task automatic run_contention();
        int order[$];
        int when[$];
        bit overlap = 0, rearm0 = 0, rearm1 = 0;
        @(negedge HCLK);
        set_req(1'b0, 1'b1, 32'h1000_0000, 1'b0, 32'h0);
        set_req(1'b1, 1'b1, 32'h2000_0000, 1'b0, 32'h0);
        PREADY = 1'b1;
        PRDATA = 32'h1111_0000;
        for (int k = 1; k <= 20 && order.size() < 4; k++) begin
            @(negedge HCLK);
            if (done0 && done1) overlap = 1;
            if (rearm0) begin req0 = 1'b1; rearm0 = 0; end
            if (rearm1) begin req1 = 1'b1; rearm1 = 0; end
            if (done0 || done1) chk("cont_rdata", rdata, 32'h1111_0000);
            if (done0) begin order.push_back(0); when.push_back(k); req0 = 1'b0; rearm0 = (order.size() < 3); end
            if (done1) begin order.push_back(1); when.push_back(k); req1 = 1'b0; rearm1 = (order.size() < 3); end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        PREADY = 1'b0;
        chk("cont_count", order.size(), 4);
        chk("cont_overlap", {31'd0, overlap}, 32'd0);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            chk($sformatf("cont_order%0d", i), order[i], i % 2);
            chk($sformatf("cont_time%0d", i), when[i], 3 * (i + 1));
        end
        repeat (3) @(negedge HCLK);
    endtask

    // Reset asserted in the middle of ACCESS
    task automatic run_reset_pulse();
        int unsigned spurious = 0;
        @(negedge HCLK);
        set_req(1'b0, 1'b1, 32'h4000_0060, 1'b1, 32'hA5A5_A5A5);
        PREADY = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("rst_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
        #2 HRESETn = 1'b0;
        #1 chk_all_zero("rst_mid");
        req0 = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge HCLK);
            if (done0 || done1 || PSEL) spurious++;
        end
        chk("rst_no_done_after", spurious, 0);
    endtask

    // Randomized traffic against a transaction-timeline model
    task automatic run_random(input int unsigned ncyc);
        bit          act = 0, terr = 0, town = 0, last = 1;
        int unsigned tg = 0, tA = 0, tdone = 0, waits;
        int          just;
        logic [31:0] m_rd = '0, ea = '0, ed = '0;
        logic        ew = 1'b0;
        bit          granted[2] = '{0, 0};
        logic        rq[2] = '{1'b0, 1'b0};
        logic [31:0] ra[2], rd[2];
        logic        rw[2];
        bit          e_psel, e_pen, e_d0, e_d1, el0, el1, w;
        for (int unsigned c = 0; c < ncyc; c++) begin
            @(negedge HCLK);
            e_psel = act && c >= tg + 1 && c <= tg + 1 + tA;
            e_pen  = act && c >= tg + 2 && c <= tg + 1 + tA;
            e_d0   = act && c == tdone && !town;
            e_d1   = act && c == tdone &&  town;
            chk("rand_ctl", {26'd0, PSEL, PENABLE, done0, done1, err0, err1},
                {26'd0, e_psel, e_pen, e_d0, e_d1, e_d0 & terr, e_d1 & terr});
            chk("rand_paddr", PADDR, ea);
            chk("rand_pwdata", PWDATA, ed);
            chk("rand_pwrite", {31'd0, PWRITE}, {31'd0, ew});
            if (e_d0 || e_d1) chk("rand_rdata", rdata, m_rd);
            just = -1;
            if (act && c == tdone) begin
                just = town;
                rq[town] = 1'b0;
                granted[town] = 0;
                act = 0;
            end
            for (int x = 0; x < 2; x++) begin
                if (x == just) continue;
                if (!rq[x]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rq[x] = 1'b1;
                        ra[x] = $urandom();
                        rd[x] = $urandom();
                        rw[x] = 1'($urandom_range(0, 1));
                    end
                end else if (!granted[x] && $urandom_range(0, 19) == 0) begin
                    rq[x] = 1'b0;
                end
            end
            if (act && c >= tg + 2 && c <= tg + 1 + tA) PREADY = !terr && (c == tg + 1 + tA);
            else PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom();
            if (act && !terr && c == tg + 1 + tA) m_rd = PRDATA;
            if (!act) begin
                el0 = rq[0] && just != 0;
                el1 = rq[1] && just != 1;
                if (el0 || el1) begin
                    w = (el0 && el1) ? !last : el1;
                    last = w;
                    act = 1;
                    tg = c;
                    town = w;
                    granted[w] = 1;
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4, 5: waits = $urandom_range(0, 2);
                        6, 7:             waits = $urandom_range(3, 6);
                        default:          waits = $urandom_range(TO - 3, TO + 2);
                    endcase
                    terr = waits >= TO;
                    tA = terr ? TO : waits + 1;
                    tdone = tg + 2 + tA;
                    ea = ra[w];
                    ed = rd[w];
                    ew = rw[w];
                    m_rd = '0;
                end
            end
            req0 = rq[0]; addr0 = ra[0]; wdata0 = rd[0]; write0 = rw[0];
            req1 = rq[1]; addr1 = ra[1]; wdata1 = rd[1]; write1 = rw[1];
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h4000_0010, 1'b0, 32'h0000_0000, 0,  32'hDEAD_BEEF, 3,  1,  1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h4000_0020, 1'b1, 32'h1234_5678, 3,  32'hCAFE_0001, 6,  4,  1'b0, 32'hCAFE_0001};
        vecs[2] = '{1'b0, 32'h4000_0030, 1'b0, 32'h0000_0000, 99, 32'h55AA_55AA, 18, 16, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b0, 32'h4000_0040, 1'b0, 32'h0000_0000, 15, 32'h0BAD_F00D, 18, 16, 1'b0, 32'h0BAD_F00D};
        vecs[4] = '{1'b1, 32'h4000_0050, 1'b0, 32'h0000_0000, 14, 32'h1357_2468, 17, 15, 1'b0, 32'h1357_2468};
        vecs[5] = '{1'b1, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1,  32'h0000_0000, 4,  2,  1'b0, 32'h0000_0000};

        @(posedge HCLK);
        #1 chk_all_zero("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk_all_zero("post_reset_idle");

        run_contention();
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        run_reset_pulse();
        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/apb_rr_master.md
APB_RR_MASTER -- requirements
Module: apb_rr_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles allowed without PREADY (legal 1..255).
REQ-002 The block SHALL have port HCLK  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port HRESETn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0, req1  input  1 each  transfer request from requester 0 and requester 1.
REQ-005 The block SHALL have ports addr0, addr1  input  32 each  transfer address per requester.
REQ-006 The block SHALL have ports write0, write1  input  1 each  per requester: 1 = write, 0 = read.
REQ-007 The block SHALL have ports wdata0, wdata1  input  32 each  write data per requester.
REQ-008 The block SHALL have ports done0, done1  output  1 each  one-cycle completion pulse per requester.
REQ-009 The block SHALL have ports err0, err1  output  1 each  timeout flag, valid only with the matching done.
REQ-010 The block SHALL have port rdata  output  32  read data, valid with any done pulse.
REQ-011 The block SHALL have ports PADDR 32, PWDATA 32, PWRITE 1, PSEL 1, PENABLE 1, all outputs: the APB master bus.
REQ-012 The block SHALL have ports PRDATA  input  32 and PREADY  input  1, the APB slave response.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP and ACCESS, all registered.
REQ-014 In IDLE, PSEL=0 and PENABLE=0; in SETUP, PSEL=1 and PENABLE=0; in ACCESS, PSEL=1 and PENABLE=1. These outputs SHALL be driven directly from registers.
REQ-015 IDLE->SETUP SHALL occur when at least one eligible request is present; otherwise the FSM SHALL remain in IDLE.
REQ-016 On IDLE->SETUP, the winner's addr, write and wdata SHALL be latched into PADDR, PWRITE and PWDATA, and SHALL be held until the next grant.
REQ-017 SETUP->ACCESS SHALL occur unconditionally after one cycle.
REQ-018 In ACCESS with PREADY=1, the FSM SHALL go to IDLE, and in that IDLE cycle the block SHALL assert done<winner>=1, err<winner>=0 and rdata=the PRDATA value sampled with PREADY.
REQ-019 Timeout: an 8-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-020 When the counter reaches TIMEOUT-1 with PREADY=0, the FSM SHALL go to IDLE and assert done<winner>=1, err<winner>=1 and rdata=0.
REQ-021 PREADY=1 in the same cycle as the timeout limit SHALL count as a normal completion (err=0).
REQ-022 Arbitration SHALL be round-robin using a last-grant register: if only one requester is eligible it SHALL win; if both are eligible, the requester not granted last SHALL win.
REQ-023 A requester whose done is asserted in the current cycle SHALL be ineligible in that cycle, so a still-high req is not re-served before the requester can drop it.
REQ-024 Requester contract: req is held high, with addr/write/wdata stable, until done; req may reassert one or more cycles after done.
REQ-025 Throughput: the minimum cost SHALL be 3 cycles per transfer (SETUP, ACCESS, IDLE/done), plus one cycle per PREADY=0 wait in ACCESS.
REQ-026 done0 and done1 SHALL never be asserted simultaneously; done and err SHALL be high for exactly one cycle per transfer.
REQ-027 A request arriving while the FSM is busy SHALL wait without loss; no request queueing beyond the req level is required.
REQ-028 A req dropped before its grant SHALL be ignored, with no done generated.

Reset
REQ-029 While HRESETn=0, the block SHALL force: FSM=IDLE; PSEL, PENABLE, PWRITE, done0/1, err0/1 = 0; PADDR, PWDATA, rdata = 0; timeout counter = 0; last-grant = 1, so requester 0 wins the first contention.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer immediately with no done pulse; after release the FSM SHALL start from IDLE.

Verification
REQ-031 Single read: req0=1, addr0=0x4000_0010, write0=0, PREADY=1, PRDATA=0xDEAD_BEEF -> PSEL high for 2 cycles, PENABLE high for 1 cycle, PADDR=0x4000_0010, done0 pulses 3 cycles after req0 with rdata=0xDEAD_BEEF and err0=0.
REQ-032 Contention: req0 and req1 rise together and are held, with done-driven drops and reasserts -> grant order 0,1,0,1; no done ever overlaps; done0 and done1 alternate every 3 cycles.
REQ-033 Wait states: write via req1, wdata1=0x1234_5678, PREADY low for 3 ACCESS cycles -> PENABLE high for 4 cycles, PWDATA stable at 0x1234_5678 throughout, done1 with err1=0.
REQ-034 Timeout: TIMEOUT=16 with PREADY stuck at 0 -> ACCESS lasts exactly 16 cycles, then done0=1, err0=1, rdata=0, PSEL=0.
REQ-035 Boundary: PREADY rises in the 16th ACCESS cycle -> normal completion with err0=0; separately, HRESETn pulsed low during ACCESS -> all outputs 0 immediately and no done pulse after release.
